// File: rtl/pool_control_if.sv
// Handshake and map bus between a pooling-stage driver and pool_control.
// The master drives start and the conv result map; the slave returns the pooled map and status.
interface pool_control_if #(
  parameter int unsigned MAPSIZE = 28
);
  localparam int unsigned HALF = MAPSIZE / 2;

  logic              start;
  logic signed [31:0] inputs  [MAPSIZE-1:0][MAPSIZE-1:0];
  logic signed [7:0]  outputs [HALF-1:0][HALF-1:0];
  logic              busy;
  logic              done;

  modport master (
    output start,
    output inputs,
    input  outputs,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  inputs,
    output outputs,
    output busy,
    output done
  );
endinterface

// File: rtl/pool_control.sv
// 2x2 stride-2 max pooling over a signed 32-bit map, one element per cycle,
// with shift / optional ReLU / int8 saturation requantization of each window maximum.
module pool_control #(
  parameter int unsigned MAPSIZE = 28,
  parameter int unsigned SHIFT   = 8,
  parameter bit          RELU    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  pool_control_if.slave bus
);
  localparam int unsigned HALF = MAPSIZE / 2;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      px_q, px_d, py_q, py_d;
  logic [1:0]         k_q, k_d;
  logic signed [31:0] max_q, max_d;
  logic               busy_q, done_q;
  logic               wr_en;
  logic [CW:0]        row, col;
  logic signed [31:0] elem;

  // k[1] selects the window row, k[0] the column
  assign row  = {py_q, k_q[1]};
  assign col  = {px_q, k_q[0]};
  assign elem = bus.inputs[row][col];

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  function automatic logic signed [7:0] requant(input logic signed [31:0] v);
    logic signed [31:0] s;
    s = v >>> SHIFT;
    if (RELU && (s < 0)) s = '0;
    if (s > 32'sd127)       return 8'sd127;
    else if (s < -32'sd128) return -8'sd128;
    else                    return s[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    k_d     = k_q;
    max_d   = max_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRead;
          px_d    = '0;
          py_d    = '0;
          k_d     = '0;
        end
      end
      StRead: begin
        // ties keep the current maximum
        if (k_q == 2'd0)       max_d = elem;
        else if (elem > max_q) max_d = elem;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = StWrite;
      end
      StWrite: begin
        wr_en = 1'b1;
        k_d   = '0;
        if (px_q == LAST) begin
          if (py_q == LAST) begin
            state_d = StDone;
          end else begin
            px_d    = '0;
            py_d    = py_q + 1'b1;
            state_d = StRead;
          end
        end else begin
          px_d    = px_q + 1'b1;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      px_q    <= '0;
      py_q    <= '0;
      k_q     <= '0;
      max_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < HALF; i++) begin
        for (int j = 0; j < HALF; j++) begin
          bus.outputs[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      k_q     <= k_d;
      max_q   <= max_d;
      // status is registered from the current state, so it trails the state by one cycle
      busy_q  <= (state_q == StRead) || (state_q == StWrite);
      done_q  <= (state_q == StDone);
      if (wr_en) bus.outputs[py_q][px_q] <= requant(max_q);
    end
  end
endmodule

// File: tb/tb_pool_control.sv
// Self-checking bench for pool_control: five instances with different parameters share
// clk/rst/start; expected window results are queued at start and popped as each WRITE lands.
module tb_pool_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  pool_control_if #(.MAPSIZE(4))  if_a ();
  pool_control_if #(.MAPSIZE(4))  if_b ();
  pool_control_if #(.MAPSIZE(4))  if_c ();
  pool_control_if #(.MAPSIZE(28)) if_d ();
  pool_control_if #(.MAPSIZE(2))  if_e ();

  assign if_a.start = start;
  assign if_b.start = start;
  assign if_c.start = start;
  assign if_d.start = start;
  assign if_e.start = start;

  pool_control #(.MAPSIZE(4),  .SHIFT(0), .RELU(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pool_control #(.MAPSIZE(4),  .SHIFT(2), .RELU(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  pool_control #(.MAPSIZE(4),  .SHIFT(2), .RELU(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
  pool_control #(.MAPSIZE(28), .SHIFT(8), .RELU(1'b1)) dut_d (.clk(clk), .rst(rst), .bus(if_d));
  pool_control #(.MAPSIZE(2),  .SHIFT(0), .RELU(1'b1)) dut_e (.clk(clk), .rst(rst), .bus(if_e));

  int ms_t [5] = '{4, 4, 4, 28, 2};
  int sh_t [5] = '{0, 2, 2, 8, 0};
  int re_t [5] = '{0, 0, 1, 1, 1};

  typedef struct {
    int d;
    int py;
    int px;
    int exp;
  } exp_t;
  exp_t sb[$];

  int m [28][28];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_out(input int d, input int py, input int px);
    case (d)
      0: return int'(if_a.outputs[py][px]);
      1: return int'(if_b.outputs[py][px]);
      2: return int'(if_c.outputs[py][px]);
      3: return int'(if_d.outputs[py][px]);
      default: return int'(if_e.outputs[py][px]);
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return if_a.busy;
      1: return if_b.busy;
      2: return if_c.busy;
      3: return if_d.busy;
      default: return if_e.busy;
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0: return if_a.done;
      1: return if_b.done;
      2: return if_c.done;
      3: return if_d.done;
      default: return if_e.done;
    endcase
  endfunction

  function automatic int qmodel(input int v, input int sh, input int re);
    int s;
    s = v >>> sh;
    if (re != 0 && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic load_map(input int d);
    for (int r = 0; r < ms_t[d]; r++) begin
      for (int c = 0; c < ms_t[d]; c++) begin
        case (d)
          0: if_a.inputs[r][c] = m[r][c];
          1: if_b.inputs[r][c] = m[r][c];
          2: if_c.inputs[r][c] = m[r][c];
          3: if_d.inputs[r][c] = m[r][c];
          default: if_e.inputs[r][c] = m[r][c];
        endcase
      end
    end
  endtask

  task automatic push_expected(input int d);
    int h;
    int mx;
    exp_t e;
    h = ms_t[d] / 2;
    for (int py = 0; py < h; py++) begin
      for (int px = 0; px < h; px++) begin
        mx = m[2*py][2*px];
        if (m[2*py][2*px+1] > mx) mx = m[2*py][2*px+1];
        if (m[2*py+1][2*px] > mx) mx = m[2*py+1][2*px];
        if (m[2*py+1][2*px+1] > mx) mx = m[2*py+1][2*px+1];
        e.d = d; e.py = py; e.px = px; e.exp = qmodel(mx, sh_t[d], re_t[d]);
        sb.push_back(e);
      end
    end
  endtask

  task automatic set_map4(input int v [16]);
    for (int i = 0; i < 16; i++) m[i/4][i%4] = v[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Full pass on instance d: start pulse, per-window scoreboard pops, done timing.
  // repulse: cycle at which start is pulsed again (0 = none).
  // old_last: value the last window must still hold before its WRITE (1000 = skip).
  task automatic run_pass(input int d, input int repulse, input int old_last);
    int n;
    int cyc;
    exp_t e;
    int got;
    n = (ms_t[d] / 2) * (ms_t[d] / 2);
    push_expected(d);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    checks++;
    if (get_busy(d) !== 1'b0) begin
      failures++;
      $display("FAIL busy_at_start d=%0d got=%b exp=0", d, get_busy(d));
    end
    for (int w = 0; w < n; w++) begin
      for (int c = 0; c < 5; c++) begin
        start = (cyc + 1 == repulse);
        tick();
        start = 1'b0;
        cyc++;
        if (cyc == 1) begin
          checks++;
          if (get_busy(d) !== 1'b1 || get_done(d) !== 1'b0) begin
            failures++;
            $display("FAIL busy_rise d=%0d busy=%b done=%b exp busy=1 done=0", d,
                     get_busy(d), get_done(d));
          end
        end
      end
      if (old_last != 1000 && w < n - 1) begin
        got = get_out(d, ms_t[d]/2 - 1, ms_t[d]/2 - 1);
        checks++;
        if (got !== old_last) begin
          failures++;
          $display("FAIL persist d=%0d w=%0d got=%0d exp=%0d", d, w, got, old_last);
        end
      end
      e = sb.pop_front();
      got = get_out(e.d, e.py, e.px);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL window d=%0d [%0d][%0d] got=%0d exp=%0d", e.d, e.py, e.px, got, e.exp);
      end
    end
    checks++;
    if (get_done(d) !== 1'b0 || get_busy(d) !== 1'b1) begin
      failures++;
      $display("FAIL pre_done d=%0d done=%b busy=%b exp done=0 busy=1", d,
               get_done(d), get_busy(d));
    end
    tick();
    checks++;
    if (get_done(d) !== 1'b1 || get_busy(d) !== 1'b0) begin
      failures++;
      $display("FAIL done_time d=%0d done=%b busy=%b exp done=1 busy=0", d,
               get_done(d), get_busy(d));
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (get_busy(d) !== 1'b0 || get_done(d) !== 1'b0 || get_out(d, 0, 0) !== 0) begin
        failures++;
        $display("FAIL reset d=%0d busy=%b done=%b out00=%0d exp 0/0/0", d,
                 get_busy(d), get_done(d), get_out(d, 0, 0));
      end
    end
  endtask

  task automatic test_basic();
    set_map4('{1, 5, -3, 2, 7, 0, -9, -1, 4, 4, 8, 8, -2, 3, 8, 6});
    load_map(0);
    run_pass(0, 0, 1000);
  endtask

  task automatic test_restart();
    // previous pass left [[7,2],[4,8]]; the last window must keep 8 until its own WRITE
    set_map4('{10, -1, 0, 0, -5, 3, 0, 1, -7, -8, 50, 49, -9, -6, 48, 51});
    load_map(0);
    run_pass(0, 0, 8);
  endtask

  task automatic test_requant();
    set_map4('{1000, 1, -600, -700, 2, 3, -800, -900, 20, 0, -3, -5, 0, 0, -4, -10});
    load_map(1);
    load_map(2);
    run_pass(1, 0, 1000);
    run_pass(2, 0, 1000);
  endtask

  task automatic test_midpass();
    int got;
    set_map4('{1, 5, -3, 2, 7, 0, -9, -1, 4, 4, 8, 8, -2, 3, 8, 6});
    load_map(0);
    run_pass(0, 7, 1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (get_busy(0) !== 1'b0 || get_done(0) !== 1'b0) begin
      failures++;
      $display("FAIL midreset_status busy=%b done=%b exp 0/0", get_busy(0), get_done(0));
    end
    for (int i = 0; i < 4; i++) begin
      got = get_out(0, i / 2, i % 2);
      checks++;
      if (got !== 0) begin
        failures++;
        $display("FAIL midreset_out [%0d][%0d] got=%0d exp=0", i / 2, i % 2, got);
      end
    end
    tick();
    tick();
    checks++;
    if (get_busy(0) !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b exp=0", get_busy(0));
    end
    run_pass(0, 0, 1000);
  endtask

  task automatic test_mapsize2();
    m[0][0] = 3; m[0][1] = -200; m[1][0] = 150; m[1][1] = 9;
    load_map(4);
    run_pass(4, 0, 1000);
  endtask

  task automatic test_big();
    int got;
    do_reset();
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) m[r][c] = (r * 28 + c) * 256;
    end
    load_map(3);
    run_pass(3, 0, 1000);
    got = get_out(3, 0, 1);
    checks++;
    if (got !== 31) begin
      failures++;
      $display("FAIL big_01 got=%0d exp=31", got);
    end
    got = get_out(3, 13, 13);
    checks++;
    if (got !== 127) begin
      failures++;
      $display("FAIL big_1313 got=%0d exp=127", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_requant();
    test_midpass();
    test_mapsize2();
    test_big();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
